// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared types and helpers for the LUT function generator
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_state_e;

    // Ceiling log2, for callers sizing cfg_ch; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lut_func_gen_if.sv
// rtl/lut_func_gen_if.sv - evaluation and table-load signal bundle
interface lut_func_gen_if #(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) ();

    logic              in_valid;
    logic [SEL_W-1:0]  in_sel;
    logic              out_valid;
    logic [NUM_CH-1:0] f;
    logic              cfg_start;
    logic [CH_W-1:0]   cfg_ch;
    logic              cfg_bit_vld;
    logic              cfg_bit;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;

    modport master (
        output in_valid, in_sel, cfg_start, cfg_ch, cfg_bit_vld, cfg_bit,
        input  out_valid, f, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  in_valid, in_sel, cfg_start, cfg_ch, cfg_bit_vld, cfg_bit,
        output out_valid, f, cfg_busy, cfg_done, cfg_err
    );

endinterface

// File: rtl/lut_mux_n.sv
// rtl/lut_mux_n.sv - combinational 2^SEL_W:1 truth-table mux
module lut_mux_n #(
    parameter int SEL_W = 3
) (
    input  logic [(1<<SEL_W)-1:0] data,
    input  logic [SEL_W-1:0]      sel,
    output logic                  y
);

    assign y = data[sel];

endmodule

// File: rtl/lut_func_gen.sv
// rtl/lut_func_gen.sv - multi-channel programmable LUT with atomic serial table load
module lut_func_gen
    import lut_pkg::*;
#(
    parameter int                     SEL_W     = 3,
    parameter int                     NUM_CH    = 2,
    parameter int                     CH_W      = 1,
    parameter logic [(1<<SEL_W)-1:0]  RST_TABLE = '0
) (
    input  logic          clk,
    input  logic          rst,
    lut_func_gen_if.slave bus
);

    localparam int              LUT_N    = 1 << SEL_W;
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [SEL_W:0]  LAST_IDX = (SEL_W+1)'(LUT_N - 1);
    localparam logic [SEL_W:0]  CNT_MAX  = (SEL_W+1)'(LUT_N);

    lut_state_e        state;
    lut_state_e        state_nxt;
    logic [SEL_W:0]    bit_cnt;
    logic [LUT_N-1:0]  shadow;
    logic [CH_W-1:0]   ch_q;
    logic [LUT_N-1:0]  tables [NUM_CH];
    logic [NUM_CH-1:0] mux_y;
    logic [NUM_CH-1:0] f_q;
    logic              out_valid_q;
    logic              err_q;
    logic              ch_ok;
    logic              start_ok;
    logic              bit_take;
    logic              last_bit;

    assign ch_ok    = {1'b0, bus.cfg_ch} < NUM_CH_L;
    assign start_ok = (state == IDLE) && bus.cfg_start && ch_ok;
    assign bit_take = (state == LOAD) && bus.cfg_bit_vld;
    assign last_bit = bit_take && (bit_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = LOAD;
            LOAD:    if (last_bit) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cfg_busy = (state != IDLE);
    assign bus.cfg_done = (state == COMMIT);
    assign bus.cfg_err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shadow  <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && bus.cfg_start && !ch_ok;
            if (start_ok) begin
                bit_cnt <= '0;
                shadow  <= '0;
                ch_q    <= bus.cfg_ch;
            end else if (bit_take && (bit_cnt != CNT_MAX)) begin
                shadow  <= {shadow[LUT_N-2:0], bus.cfg_bit};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Tables only change in COMMIT, so evaluation sees either the old or the new table whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tables[c] <= RST_TABLE;
            end
        end else if (state == COMMIT) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_q == CH_W'(c)) begin
                    tables[c] <= shadow;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        lut_mux_n #(.SEL_W(SEL_W)) u_mux (
            .data (tables[g]),
            .sel  (bus.in_sel),
            .y    (mux_y[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                f_q <= mux_y;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;

endmodule
